// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Load/store request bus between the pipeline MEM stage (master) and the
//   data-memory responder (slave).
//
//   req       master->slave  access request, sampled while ready=1
//   we        master->slave  1=store, 0=load
//   size      master->slave  00 word, 01 half, 10 byte, 11 illegal
//   signed_ld master->slave  loads: 1=sign-extend, 0=zero-extend
//   addr      master->slave  byte address
//   wdata     master->slave  store data (low bits for half/byte)
//   ready     slave->master  responder idle, can accept
//   stall     slave->master  pipeline must hold the MEM stage
//   rsp_valid slave->master  one-cycle response strobe
//   rdata     slave->master  load result, 0 for stores/errors
//   err       slave->master  misaligned / out-of-range / illegal size
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        signed_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, signed_ld, addr, wdata,
        input  ready, stall, rsp_valid, rdata, err
    );

    modport slave (
        input  req, we, size, signed_ld, addr, wdata,
        output ready, stall, rsp_valid, rdata, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Multi-cycle data-memory responder. Accepts one word/half/byte access over
//   a req/ready handshake, waits LATENCY cycles, merges byte lanes on stores,
//   sign/zero-extends loads and returns a one-cycle response. Stall holds the
//   pipeline from the request cycle until the response cycle.
//
//   Parameters:
//     DEPTH   memory size in 32-bit words (power of 2, >= 2)
//     LATENCY cycles spent in BUSY before the response (1..15)
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset (memory contents are kept)
//     bus    data_mem_responder_if.slave request/response bus
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ERR,
        S_RESP
    } state_t;

    state_t       state;
    logic [3:0]   cnt;

    // Request captured at accept; only the address bits that index the array
    // plus the lane offset are kept.
    logic         we_q;
    logic [1:0]   size_q;
    logic         signed_q;
    logic [AW+1:0] addr_q;
    logic [31:0]  wdata_q;

    logic         ready_q;
    logic         rsp_valid_q;
    logic         err_q;
    logic [31:0]  rdata_q;

    logic [31:0]  mem [DEPTH];

    logic         acc_err;
    logic         commit;
    logic [31:0]  rd_word;
    logic [31:0]  shifted;
    logic [31:0]  ld_word;
    logic [31:0]  lane_data;
    logic [3:0]   lane_mask;
    logic [31:0]  wr_word;

    // Error classification of the live request, used on the accept edge.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_err = 1'b0;
        case (bus.size)
            2'b00:   acc_err = (bus.addr[1:0] != 2'b00);
            2'b01:   acc_err = bus.addr[0];
            2'b10:   acc_err = 1'b0;
            default: acc_err = 1'b1;
        endcase
        if ({2'b00, bus.addr[31:2]} >= 32'(DEPTH))
            acc_err = 1'b1;
    end

    // Final BUSY cycle: the access is performed on the edge that ends it.
    assign commit  = (state == S_BUSY) && (cnt == 4'd0);
    assign rd_word = mem[addr_q[AW+1:2]];

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign shifted = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_word = shifted;
        case (size_q)
            2'b10:   ld_word = {{24{signed_q & shifted[7]}},  shifted[7:0]};
            2'b01:   ld_word = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: ld_word = shifted;
        endcase
    end

    // Store path: replicate the store data across lanes and pick the
    // addressed lanes over the current word (read-modify-write).
    always_comb begin
        lane_data = wdata_q;
        lane_mask = 4'b1111;
        case (size_q)
            2'b10: begin
                lane_data = {4{wdata_q[7:0]}};
                lane_mask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                lane_data = {2{wdata_q[15:0]}};
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = wdata_q;
                lane_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i])
                wr_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    // NOTE: the memory array has no reset; it is a plain clocked write so it
    // maps onto RAM. While rst_n is low the FSM sits in IDLE, so an in-flight
    // store can never commit.
    always_ff @(posedge clk) begin
        if (commit && we_q)
            mem[addr_q[AW+1:2]] <= wr_word;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        size_q   <= bus.size;
                        signed_q <= bus.signed_ld;
                        addr_q   <= bus.addr[AW+1:0];
                        wdata_q  <= bus.wdata;
                        ready_q  <= 1'b0;
                        if (acc_err) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b0;
                        rdata_q     <= we_q ? 32'd0 : ld_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ERR: begin
                    state       <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    err_q       <= 1'b1;
                    rdata_q     <= 32'd0;
                end
                default: begin  // S_RESP
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    rdata_q     <= 32'd0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    // Stall covers the request cycle itself, so it cannot be registered; it
    // drops in RESP so the pipeline captures rdata/err on the edge ending it.
    assign bus.stall     = ((state == S_IDLE) && bus.req) ||
                           (state == S_BUSY) || (state == S_ERR);
    assign bus.ready     = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. The main instance runs with
//   LATENCY=2 against a byte-array reference model; a second instance with
//   LATENCY=1 is used for the back-to-back (req held high) behaviour.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int LAT1  = 1;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk;
    logic rst_n;

    data_mem_responder_if bus ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte-addressed little-endian memory.
    logic [7:0] mbytes [DEPTH*4];

    // Results of the most recent access.
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_edges;
    int          last_stall;

    logic [31:0] init_words [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++)
            v[8*i +: 8] = mbytes[int'(a) + i];
        return v;
    endfunction

    // Access outcome from the architectural rules: alignment, range, lanes,
    // extension. Updates the model memory for legal stores.
    function automatic void model_access(input logic we, input logic [1:0] size,
                                         input logic sgn, input logic [31:0] a,
                                         input logic [31:0] wd,
                                         output logic e, output logic [31:0] rd);
        int nb;
        longint unsigned v;
        nb = (size == SZ_W) ? 4 : (size == SZ_H) ? 2 : 1;
        e  = (size == SZ_X) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
        rd = 32'd0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < nb; i++)
                mbytes[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v = v + (longint'(mbytes[int'(a) + i]) << (8 * i));
            if (sgn && nb < 4 && v[8*nb-1])
                v = v + (64'h1_0000_0000 - (64'd1 << (8 * nb)));
            rd = v[31:0];
        end
    endfunction

    // One complete access on the LATENCY=2 instance, checked against the model.
    // Edge counts include the accept edge itself.
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        int          stall_cnt;
        bit          got;
        int          exp_edges;

        model_access(we, size, sgn, a, wd, exp_err, exp_rd);
        exp_edges = exp_err ? 2 : LAT + 1;

        @(negedge clk);
        check("ready_before_req", 32'(bus.ready), 32'd1);
        bus.req       = 1'b1;
        bus.we        = we;
        bus.size      = size;
        bus.signed_ld = sgn;
        bus.addr      = a;
        bus.wdata     = wd;
        #1;
        stall_cnt = bus.stall ? 1 : 0;

        @(posedge clk);          // accept edge
        #1;
        bus.req   = 1'b0;
        bus.wdata = $urandom;    // must be ignored after accept
        bus.addr  = $urandom;
        n = 1;
        got = 1'b0;
        if (bus.stall) stall_cnt++;

        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rsp_valid) got = 1'b1;
            else if (bus.stall) stall_cnt++;
        end
        check("rsp_timeout", 32'(got), 32'd1);

        last_rdata = bus.rdata;
        last_err   = bus.err;
        last_edges = n;
        last_stall = stall_cnt;

        if (got) begin
            check("rsp_err",       32'(bus.err),   32'(exp_err));
            check("rsp_rdata",     bus.rdata,      exp_rd);
            check("rsp_edges",     32'(n),         32'(exp_edges));
            check("stall_cycles",  32'(stall_cnt), 32'(exp_edges));
            check("resp_stall_lo", 32'(bus.stall), 32'd0);
            check("resp_ready_lo", 32'(bus.ready), 32'd0);
            @(posedge clk);
            #1;
            check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
            check("idle_ready",    32'(bus.ready),     32'd1);
            check("idle_rdata0",   bus.rdata,          32'd0);
            check("idle_err0",     32'(bus.err),       32'd0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] saved;
        int          accepts [$];
        logic        rdy;
        logic        prev_rsp;
        logic        we_r;
        logic [1:0]  sz_r;
        logic [31:0] a_r;

        bus.req = 0; bus.we = 0; bus.size = 0; bus.signed_ld = 0; bus.addr = 0; bus.wdata = 0;
        bus1.req = 0; bus1.we = 0; bus1.size = 0; bus1.signed_ld = 0; bus1.addr = 0; bus1.wdata = 0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",     32'(bus.ready),     32'd1);
        check("rst_stall",     32'(bus.stall),     32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata",     bus.rdata,          32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        rst_n = 1'b1;

        // Give the first 16 words known contents
        for (int i = 0; i < 16; i++) begin
            init_words[i] = $urandom;
            access(1'b1, SZ_W, 1'b0, 32'(i * 4), init_words[i]);
        end

        // Word store then load
        access(1'b1, SZ_W, 1'b0, 32'h4, 32'h11223344);
        check("st4_err",   32'(last_err), 32'd0);
        check("st4_rdata", last_rdata,    32'd0);
        check("st4_edges", 32'(last_edges), 32'd3);
        access(1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        check("ld4_value", last_rdata,      32'h11223344);
        check("ld4_stall", 32'(last_stall), 32'd3);

        // Byte lane merge
        access(1'b1, SZ_B, 1'b0, 32'h5, 32'hFFFF_FFAB);
        access(1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        check("merge_ld4", last_rdata, 32'h1122AB44);

        // Extension
        access(1'b1, SZ_W, 1'b0, 32'h8, 32'h00008080);
        access(1'b0, SZ_B, 1'b1, 32'h8, 32'h0);
        check("lb_signed",   last_rdata, 32'hFFFFFF80);
        access(1'b0, SZ_B, 1'b0, 32'h8, 32'h0);
        check("lb_unsigned", last_rdata, 32'h00000080);
        access(1'b0, SZ_H, 1'b1, 32'h8, 32'h0);
        check("lh_signed",   last_rdata, 32'hFFFF8080);
        access(1'b0, SZ_H, 1'b0, 32'hA, 32'h0);
        check("lh_upper",    last_rdata, 32'h00000000);

        // Errors
        access(1'b1, SZ_H, 1'b0, 32'h3, 32'h0000BEEF);
        check("mis_err",   32'(last_err),   32'd1);
        check("mis_rdata", last_rdata,      32'd0);
        check("mis_edges", 32'(last_edges), 32'd2);
        access(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        check("mis_untouched", last_rdata, init_words[0]);
        access(1'b0, SZ_X, 1'b0, 32'h0, 32'h0);
        check("size11_err", 32'(last_err), 32'd1);
        access(1'b0, SZ_W, 1'b0, 32'(DEPTH * 4), 32'h0);
        check("range_err",  32'(last_err), 32'd1);
        access(1'b1, SZ_B, 1'b0, 32'(DEPTH * 4 - 1), 32'h5A);
        check("last_byte_ok", 32'(last_err), 32'd0);

        // Reset while a store to 0x10 is in BUSY
        saved = model_word(32'h10);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_W; bus.addr = 32'h10; bus.wdata = ~saved;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("abort_busy", 32'(bus.ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.ready),     32'd1);
        check("abort_stall", 32'(bus.stall),     32'd0);
        check("abort_rsp",   32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        check("abort_discarded", last_rdata, saved);

        // Randomized accesses against the model, mostly within the
        // initialised region, some out of range.
        for (int k = 0; k < 60; k++) begin
            we_r = 1'($urandom_range(0, 1));
            sz_r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                a_r = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else
                a_r = 32'($urandom_range(0, 63));
            access(we_r, sz_r, 1'($urandom_range(0, 1)), a_r, $urandom);
        end

        // Req held high on the LATENCY=1 instance
        @(negedge clk);
        bus1.req = 1'b1; bus1.we = 1'b1; bus1.size = SZ_W; bus1.addr = 32'h20; bus1.wdata = 32'hCAFE0001;
        prev_rsp = 1'b0;
        for (int c = 0; c < 30; c++) begin
            rdy = bus1.ready;
            @(posedge clk);
            if (rdy) accepts.push_back(c);
            #1;
            check("stream_overlap",  32'(bus1.rsp_valid & bus1.ready), 32'd0);
            check("stream_one_shot", 32'(bus1.rsp_valid & prev_rsp),   32'd0);
            prev_rsp = bus1.rsp_valid;
            @(negedge clk);
        end
        bus1.req = 1'b0;
        check("stream_accepts", 32'(accepts.size()), 32'd10);
        for (int i = 1; i < accepts.size(); i++)
            check("stream_spacing", 32'(accepts[i] - accepts[i-1]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
